// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the oversampled SPI slave memory port.
// Holds the frame FSM state encoding and the default command codes.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } spi_state_t;

  localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h55;
  localparam logic [7:0] CMD_READ_DEFAULT  = 8'h56;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous level, plus single-clk
// rising/falling pulses derived from the synchronised value.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     = sync_q[STAGES-1] & ~prev_q;
  assign fall     = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_mem.sv
// SPI slave in the system clock domain: decodes command/address/data frames
// into a one-cycle-latency memory port with burst auto-increment.
module spi_slave_mem
  import spi_slave_pkg::*;
#(
  parameter int               CMD_W       = 8,
  parameter int               ADDR_W      = 24,
  parameter int               DATA_W      = 32,
  parameter logic             CPOL        = 1'b0,
  parameter logic             CPHA        = 1'b0,
  parameter logic [CMD_W-1:0] CMD_WRITE   = CMD_W'(CMD_WRITE_DEFAULT),
  parameter logic [CMD_W-1:0] CMD_READ    = CMD_W'(CMD_READ_DEFAULT),
  parameter int               SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              din,
  output logic              dout,
  output logic              dout_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              cmd_err,
  output logic              word_done
);

  localparam int MAX_W = max3(CMD_W, ADDR_W, DATA_W);
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  // Level of the synchronised sclk right after a sample edge.
  localparam logic SAMPLE_LEVEL = (CPOL == CPHA);

  spi_state_t             state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [MAX_W-2:0]       rx_shift;
  logic [MAX_W-1:0]       rx_next;
  logic [DATA_W-1:0]      tx_shift;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   din_sync;
  logic                   is_read;
  logic                   rd_capture;
  logic                   field_last;
  logic                   counting;
  logic                   sclk_sync, sclk_rise, sclk_fall;
  logic                   cs_sync, cs_rise, cs_fall;
  logic                   sample_pulse, shift_pulse;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sclk),
    .sync_out (sclk_sync),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (cs),
    .sync_out (cs_sync),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // din goes through the same depth as sclk so it lines up with the edge pulse.
  always_ff @(posedge clk) begin
    if (rst) din_sync_q <= '0;
    else     din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
  end

  assign din_sync     = din_sync_q[SYNC_STAGES-1];
  assign sample_pulse = (sclk_rise | sclk_fall) & (sclk_sync == SAMPLE_LEVEL) & ~cs_sync;
  assign shift_pulse  = (sclk_rise | sclk_fall) & (sclk_sync != SAMPLE_LEVEL) & ~cs_sync;
  assign rx_next      = {rx_shift, din_sync};

  always_comb begin
    field_last = 1'b0;
    counting   = 1'b0;
    case (state)
      CMD:          begin field_last = (bit_cnt == CMD_LAST);  counting = 1'b1; end
      ADDR:         begin field_last = (bit_cnt == ADDR_LAST); counting = 1'b1; end
      WDATA, RDATA: begin field_last = (bit_cnt == DATA_LAST); counting = 1'b1; end
      default:      begin field_last = 1'b0;                   counting = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      is_read    <= 1'b0;
      rd_capture <= 1'b0;
      dout       <= 1'b0;
      dout_oe    <= 1'b0;
      mem_addr   <= '0;
      mem_wr_en  <= 1'b0;
      mem_wdata  <= '0;
      mem_rd_en  <= 1'b0;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
      cmd_err    <= 1'b0;
      word_done  <= 1'b0;
      rd_capture <= mem_rd_en;
      if (cs_fall)      busy <= 1'b1;
      else if (cs_rise) busy <= 1'b0;
      // Write address advances the clk after the strobe so the strobe sees the old one.
      if (mem_wr_en) mem_addr <= mem_addr + ADDR_W'(1);

      if (cs_sync) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        is_read  <= 1'b0;
        dout     <= 1'b0;
        dout_oe  <= 1'b0;
      end else begin
        if (sample_pulse && counting) begin
          bit_cnt <= field_last ? '0 : bit_cnt + CNT_W'(1);
          if (state != RDATA) rx_shift <= rx_next[MAX_W-2:0];
        end

        case (state)
          IDLE: if (cs_fall) state <= CMD;
          CMD: if (sample_pulse && field_last) begin
            if (rx_next[CMD_W-1:0] == CMD_WRITE) begin
              state   <= ADDR;
              is_read <= 1'b0;
            end else if (rx_next[CMD_W-1:0] == CMD_READ) begin
              state   <= ADDR;
              is_read <= 1'b1;
            end else begin
              state   <= IGNORE;
              cmd_err <= 1'b1;
            end
          end
          ADDR: if (sample_pulse && field_last) begin
            mem_addr <= rx_next[ADDR_W-1:0];
            if (is_read) begin
              state     <= RDATA;
              mem_rd_en <= 1'b1;
            end else begin
              state <= WDATA;
            end
          end
          WDATA: if (sample_pulse && field_last) begin
            mem_wr_en <= 1'b1;
            mem_wdata <= rx_next[DATA_W-1:0];
            word_done <= 1'b1;
          end
          RDATA: begin
            if (sample_pulse && field_last) begin
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_rd_en <= 1'b1;
              word_done <= 1'b1;
            end
            if (shift_pulse) begin
              dout     <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              dout_oe  <= 1'b1;
            end
            // Read data lands well before the next shift edge, so it takes priority here.
            if (rd_capture) tx_shift <= mem_rdata;
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_mem.sv
// Scoreboard bench for spi_slave_mem: a mode-0 and a mode-3 instance share
// cs/din, each with its own SCLK and memory model; a monitor checks strobes.
`timescale 1ns/1ps
module tb_spi_slave_mem;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst, cs, din, sclk_a, sclk_b;
  logic        dout_a, dout_oe_a, mem_wr_en_a, mem_rd_en_a, busy_a, cmd_err_a, word_done_a;
  logic        dout_b, dout_oe_b, mem_wr_en_b, mem_rd_en_b, busy_b, cmd_err_b, word_done_b;
  logic [23:0] mem_addr_a, mem_addr_b;
  logic [31:0] mem_wdata_a, mem_wdata_b;
  logic [31:0] mem_rdata_a = '0;
  logic [31:0] mem_rdata_b = '0;

  typedef struct {
    int          dut;
    logic [2:0]  kind;
    logic        wd;
    logic [23:0] addr;
    logic [31:0] data;
  } txn_t;

  localparam logic [2:0] K_WR = 3'b100;
  localparam logic [2:0] K_RD = 3'b010;
  localparam logic [2:0] K_ER = 3'b001;

  txn_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  spi_slave_mem #(.CPOL(1'b0), .CPHA(1'b0)) dut_a (
    .clk(clk), .rst(rst), .sclk(sclk_a), .cs(cs), .din(din),
    .dout(dout_a), .dout_oe(dout_oe_a), .mem_addr(mem_addr_a),
    .mem_wr_en(mem_wr_en_a), .mem_wdata(mem_wdata_a), .mem_rd_en(mem_rd_en_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a), .cmd_err(cmd_err_a), .word_done(word_done_a)
  );

  spi_slave_mem #(.CPOL(1'b1), .CPHA(1'b1)) dut_b (
    .clk(clk), .rst(rst), .sclk(sclk_b), .cs(cs), .din(din),
    .dout(dout_b), .dout_oe(dout_oe_b), .mem_addr(mem_addr_b),
    .mem_wr_en(mem_wr_en_b), .mem_wdata(mem_wdata_b), .mem_rd_en(mem_rd_en_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b), .cmd_err(cmd_err_b), .word_done(word_done_b)
  );

  function automatic logic [31:0] memModel(input logic [23:0] a);
    if (a == 24'h000020) return 32'h88888888;
    return {a[7:0], ~a[7:0], a[7:0] ^ 8'h5A, 8'hC3};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en_a) mem_rdata_a <= memModel(mem_addr_a);
    if (mem_rd_en_b) mem_rdata_b <= memModel(mem_addr_b);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int d, input logic [2:0] k, input logic w,
                         input logic [23:0] a, input logic [31:0] dt);
    txn_t t;
    t.dut = d; t.kind = k; t.wd = w; t.addr = a; t.data = dt;
    exp_q.push_back(t);
  endtask

  task automatic checkDut(input int id, input logic wr, input logic rd, input logic err,
                          input logic wd, input logic [23:0] addr, input logic [31:0] wdata);
    txn_t e;
    if (wr || rd || err || wd) begin
      if (exp_q.size() == 0) begin
        checkOutput($sformatf("unexpected_event_dut%0d", id), 64'({wr, rd, err, wd}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_dut", 64'(id), 64'(e.dut));
        checkOutput("event_kind", 64'({wr, rd, err}), 64'(e.kind));
        checkOutput("word_done", 64'(wd), 64'(e.wd));
        if (wr || rd) checkOutput("mem_addr", 64'(addr), 64'(e.addr));
        if (wr) checkOutput("mem_wdata", 64'(wdata), 64'(e.data));
      end
    end
  endtask

  always @(negedge clk) begin
    checkDut(0, mem_wr_en_a, mem_rd_en_a, cmd_err_a, word_done_a, mem_addr_a, mem_wdata_a);
    checkDut(1, mem_wr_en_b, mem_rd_en_b, cmd_err_b, word_done_b, mem_addr_b, mem_wdata_b);
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input int id);
    if (id == 0) begin
      checkOutput("rst_ctl_a", 64'({dout_a, dout_oe_a, mem_wr_en_a, mem_rd_en_a, busy_a, cmd_err_a, word_done_a}), 64'd0);
      checkOutput("rst_addr_a", 64'(mem_addr_a), 64'd0);
      checkOutput("rst_wdata_a", 64'(mem_wdata_a), 64'd0);
    end else begin
      checkOutput("rst_ctl_b", 64'({dout_b, dout_oe_b, mem_wr_en_b, mem_rd_en_b, busy_b, cmd_err_b, word_done_b}), 64'd0);
      checkOutput("rst_addr_b", 64'(mem_addr_b), 64'd0);
      checkOutput("rst_wdata_b", 64'(mem_wdata_b), 64'd0);
    end
  endtask

  // Plays one master frame MSB first; samples MISO just before each sample edge.
  task automatic applyStimulus(input int id, input logic [127:0] bits, input int nbits,
                               input int oe_from, input bit end_cs, output logic [127:0] rx);
    rx = '0;
    cs = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (id == 1) sclk_b = 1'b0;
      din = bits[nbits-1-i];
      waitClk(HALF);
      rx = {rx[126:0], (id == 0) ? dout_a : dout_b};
      checkOutput($sformatf("dout_oe_bit%0d", i), 64'((id == 0) ? dout_oe_a : dout_oe_b), 64'(i >= oe_from));
      if (i == 0) checkOutput("busy_in_frame", 64'((id == 0) ? busy_a : busy_b), 64'd1);
      if (id == 0) sclk_a = 1'b1; else sclk_b = 1'b1;
      waitClk(HALF);
      if (id == 0) sclk_a = 1'b0;
    end
    if (end_cs) begin
      waitClk(HALF);
      cs  = 1'b1;
      din = 1'b0;
      waitClk(4 * HALF);
      checkOutput("busy_after_frame", 64'((id == 0) ? busy_a : busy_b), 64'd0);
    end
  endtask

  initial begin
    logic [127:0] rx;
    rst = 1'b1; cs = 1'b1; din = 1'b0; sclk_a = 1'b0; sclk_b = 1'b1;
    waitClk(5);
    checkResetState(0);
    checkResetState(1);
    rst = 1'b0;
    waitClk(5);

    for (int m = 0; m < 2; m++) begin
      $display("[TB] single write and burst read, dut %0d", m);
      pushExp(m, K_WR, 1'b1, 24'h000010, 32'hDEADBEEF);
      applyStimulus(m, 128'({8'h55, 24'h000010, 32'hDEADBEEF}), 64, 1000, 1'b1, rx);

      pushExp(m, K_RD, 1'b0, 24'h000020, 32'h0);
      pushExp(m, K_RD, 1'b1, 24'h000021, 32'h0);
      pushExp(m, K_RD, 1'b1, 24'h000022, 32'h0);
      applyStimulus(m, 128'({8'h56, 24'h000020, 64'h0}), 96, 32, 1'b1, rx);
      checkOutput("miso_data", rx[63:0], 64'h88888888_21DE7BC3);
    end

    $display("[TB] burst write across address wrap");
    pushExp(0, K_WR, 1'b1, 24'hFFFFFF, 32'h12345678);
    pushExp(0, K_WR, 1'b1, 24'h000000, 32'hCAFEF00D);
    applyStimulus(0, 128'({8'h55, 24'hFFFFFF, 32'h12345678, 32'hCAFEF00D}), 96, 1000, 1'b1, rx);

    $display("[TB] invalid command");
    pushExp(0, K_ER, 1'b0, 24'h0, 32'h0);
    applyStimulus(0, 128'({8'hA5, 56'h0123456789ABCD}), 64, 1000, 1'b1, rx);

    $display("[TB] write aborted after 20 data bits, then a clean write");
    applyStimulus(0, 128'({8'h55, 24'h000100, 20'hA5A5A}), 52, 1000, 1'b1, rx);
    pushExp(0, K_WR, 1'b1, 24'h000100, 32'h0BADC0DE);
    applyStimulus(0, 128'({8'h55, 24'h000100, 32'h0BADC0DE}), 64, 1000, 1'b1, rx);

    $display("[TB] reset in the middle of a read");
    pushExp(0, K_RD, 1'b0, 24'h000040, 32'h0);
    applyStimulus(0, 128'({8'h56, 24'h000040, 10'h0}), 42, 32, 1'b0, rx);
    checkOutput("mid_read_oe", 64'(dout_oe_a), 64'd1);
    rst = 1'b1;
    waitClk(1);
    checkResetState(0);
    waitClk(2);
    cs  = 1'b1;
    rst = 1'b0;
    waitClk(20);

    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
